// File: rtl/regfile_sb_pkg.sv
// Shared types and sizes for the scoreboarded register file.
package regfile_sb_pkg;
    localparam int NREG = 32;
    localparam int RNW  = 5;

    typedef logic [RNW-1:0]  regnum_t;
    typedef logic [NREG-1:0] onehot_t;
endpackage

// File: rtl/dec5e.sv
// 5-to-32 decoder with enable; all outputs low when ena is low.
module dec5e
    import regfile_sb_pkg::*;
(
    input  regnum_t n,
    input  logic    ena,
    output onehot_t e
);
    always_comb begin
        e = '0;
        if (ena) begin
            e[n] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// 32-entry register file with two forwarding read ports, one write port
// and a per-register busy scoreboard driving the issue-stage stall.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int FWD = 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [4:0]    rna,
    input  logic [4:0]    rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we,
    input  logic [4:0]    wn,
    input  logic [DW-1:0] d,
    input  logic          iss_v,
    input  logic [4:0]    iss_wn,
    input  logic          use_a,
    input  logic          use_b,
    output logic          stall,
    output logic [31:0]   busy
);
    logic [DW-1:0] regs_q [NREG];
    onehot_t       busy_q;
    onehot_t       busy_d;
    onehot_t       wen;
    onehot_t       sset_raw;
    onehot_t       sset;
    onehot_t       ebusy;
    logic          iss_ok;

    dec5e u_dec_wr (
        .n   (wn),
        .ena (we),
        .e   (wen)
    );

    assign iss_ok = iss_v & ~stall;

    dec5e u_dec_iss (
        .n   (iss_wn),
        .ena (iss_ok),
        .e   (sset_raw)
    );

    assign sset = {sset_raw[NREG-1:1], 1'b0};

    // A write finishing this cycle frees its register for the issuing instruction.
    assign ebusy = busy_q & ~wen;

    always_comb begin
        stall = 1'b0;
        if (iss_v) begin
            stall = (use_a & ebusy[rna]) | (use_b & ebusy[rnb]) | ebusy[iss_wn];
        end
    end

    // Set wins over clear: the issuing instruction is younger than the writeback.
    assign busy_d = ebusy | sset;
    assign busy   = busy_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 1; i < NREG; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= d;
                end
            end
        end
    end

    always_comb begin
        qa = '0;
        if (rna != '0) begin
            if ((FWD != 0) && we && (wn == rna)) begin
                qa = d;
            end else begin
                qa = regs_q[rna];
            end
        end
    end

    always_comb begin
        qb = '0;
        if (rnb != '0) begin
            if ((FWD != 0) && we && (wn == rnb)) begin
                qb = d;
            end else begin
                qb = regs_q[rnb];
            end
        end
    end
endmodule
